flex_bus_initiator: RTL



---
 rtl/flex_bus_initiator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/flex_bus_initiator.sv
// Flex register bus initiator: turns one requester command into one bus transaction
// that ends on slave ack or on a wait timeout, then hands back read data and an error flag.
module flex_bus_initiator #(
  parameter int unsigned addr_bus_width = 16,
  parameter int unsigned data_bus_width = 16,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [addr_bus_width-1:0] cmd_addr_i,
  input  logic [data_bus_width-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [data_bus_width-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [addr_bus_width-1:0] bus_addr_o,
  output logic                      bus_write_o,
  output logic                      bus_read_o,
  output logic [data_bus_width-1:0] bus_wdata_o,
  input  logic [data_bus_width-1:0] bus_rdata_i,
  input  logic                      bus_ack_i,
  output logic [7:0]                timeout_cnt_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                    state_q;
  logic [CW-1:0]             wait_q;
  logic [CW-1:0]             wait_d;
  logic                      cmd_ready_q;
  logic                      rsp_valid_q;
  logic [data_bus_width-1:0] rsp_rdata_q;
  logic                      rsp_err_q;
  logic [addr_bus_width-1:0] bus_addr_q;
  logic [data_bus_width-1:0] bus_wdata_q;
  logic                      bus_write_q;
  logic                      bus_read_q;
  logic [7:0]                timeout_cnt_q;
  logic [7:0]                timeout_cnt_d;
  logic                      timed_out;

  // Wait-expiry detection and saturating timeout-count increment
  always_comb begin
    timed_out     = 1'b0;
    wait_d        = wait_q + CW'(1);
    timeout_cnt_d = timeout_cnt_q;
    if (TIMEOUT != 0) begin
      timed_out = (wait_q == WAIT_LAST);
    end else begin
      timed_out = 1'b0;
    end
    if (timeout_cnt_q == 8'hFF) begin
      timeout_cnt_d = 8'hFF;
    end else begin
      timeout_cnt_d = timeout_cnt_q + 8'd1;
    end
  end

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_write_q   <= 1'b0;
      bus_read_q    <= 1'b0;
      timeout_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            bus_addr_q  <= cmd_addr_i;
            bus_wdata_q <= cmd_wdata_i;
            bus_write_q <= cmd_we_i;
            bus_read_q  <= !cmd_we_i;
            wait_q      <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // Ack is checked first so a last-cycle ack beats the timeout
          if (bus_ack_i) begin
            rsp_rdata_q <= bus_read_q ? bus_rdata_i : '0;
            rsp_err_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timed_out) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            timeout_cnt_q <= timeout_cnt_d;
            bus_write_q   <= 1'b0;
            bus_read_q    <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            wait_q <= wait_d;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          bus_write_q <= 1'b0;
          bus_read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign bus_write_o   = bus_write_q;
  assign bus_read_o    = bus_read_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule
